// File: rtl/id_stage_pkg.sv
// id_stage_pkg: shared widths, ALU/MEM/exception encodings and RV32I opcode/funct constants
// Revision: 1.0
`default_nettype none

package id_stage_pkg;

    localparam int WORD_DATA_BUS = 32;
    localparam int REG_ADDR_BUS  = 5;

    localparam logic [3:0] ALU_OP_NOP  = 4'd0;
    localparam logic [3:0] ALU_OP_ADD  = 4'd1;
    localparam logic [3:0] ALU_OP_SUB  = 4'd2;
    localparam logic [3:0] ALU_OP_SLT  = 4'd3;
    localparam logic [3:0] ALU_OP_SLTU = 4'd4;
    localparam logic [3:0] ALU_OP_XOR  = 4'd5;
    localparam logic [3:0] ALU_OP_OR   = 4'd6;
    localparam logic [3:0] ALU_OP_AND  = 4'd7;
    localparam logic [3:0] ALU_OP_SLL  = 4'd8;
    localparam logic [3:0] ALU_OP_SRL  = 4'd9;
    localparam logic [3:0] ALU_OP_SRA  = 4'd10;

    // Three bits hold NOP plus seven accesses; half-word store has no code and decodes as illegal.
    localparam logic [2:0] MEM_OP_NOP = 3'd0;
    localparam logic [2:0] MEM_OP_LB  = 3'd1;
    localparam logic [2:0] MEM_OP_LH  = 3'd2;
    localparam logic [2:0] MEM_OP_LW  = 3'd3;
    localparam logic [2:0] MEM_OP_LBU = 3'd4;
    localparam logic [2:0] MEM_OP_LHU = 3'd5;
    localparam logic [2:0] MEM_OP_SB  = 3'd6;
    localparam logic [2:0] MEM_OP_SW  = 3'd7;

    localparam logic [1:0] EXP_NONE    = 2'd0;
    localparam logic [1:0] EXP_ILLEGAL = 2'd1;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

endpackage

`default_nettype wire

// File: rtl/id_stage_decoder.sv
// id_stage_decoder: combinational RV32I decode, operand select, branch resolution, hazard detect.
// Optional macro ID_FWD_EN enables EX/MEM operand forwarding. Revision: 1.0
`default_nettype none

module id_stage_decoder
    import id_stage_pkg::*;
(
    input  logic [WORD_DATA_BUS-1:0] i_pc,
    input  logic [WORD_DATA_BUS-1:0] i_insn,
    input  logic                     i_if_en,
    input  logic                     i_stall,
    input  logic                     i_flush,
    output logic [REG_ADDR_BUS-1:0]  o_rs1,
    output logic [REG_ADDR_BUS-1:0]  o_rs2,
    input  logic [WORD_DATA_BUS-1:0] i_rf_data_0,
    input  logic [WORD_DATA_BUS-1:0] i_rf_data_1,
    input  logic                     i_ex_en,
    input  logic                     i_ex_gpr_we,
    input  logic [REG_ADDR_BUS-1:0]  i_ex_dst_addr,
    input  logic                     i_ex_is_load,
    input  logic [WORD_DATA_BUS-1:0] i_ex_fwd_data,
    input  logic                     i_mem_en,
    input  logic                     i_mem_gpr_we,
    input  logic [REG_ADDR_BUS-1:0]  i_mem_dst_addr,
    input  logic [WORD_DATA_BUS-1:0] i_mem_fwd_data,
    output logic                     o_br_taken,
    output logic [WORD_DATA_BUS-1:0] o_br_addr,
    output logic                     o_ld_hazard,
    output logic [3:0]               o_alu_op,
    output logic [WORD_DATA_BUS-1:0] o_alu_in_0,
    output logic [WORD_DATA_BUS-1:0] o_alu_in_1,
    output logic [2:0]               o_mem_op,
    output logic [WORD_DATA_BUS-1:0] o_mem_wr_data,
    output logic [REG_ADDR_BUS-1:0]  o_dst_addr,
    output logic                     o_gpr_we,
    output logic [1:0]               o_exp_code
);

    logic [6:0]               w_opcode;
    logic [2:0]               w_funct3;
    logic [6:0]               w_funct7;
    logic [REG_ADDR_BUS-1:0]  w_rd;
    logic [WORD_DATA_BUS-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
    logic [WORD_DATA_BUS-1:0] w_rs1_data, w_rs2_data;
    logic [WORD_DATA_BUS-1:0] w_target;
    logic                     w_use_rs1, w_use_rs2, w_illegal;
    logic                     w_is_jal, w_is_jalr, w_is_branch;
    logic                     w_br_cond, w_redirect;

    assign w_opcode = i_insn[6:0];
    assign w_rd     = i_insn[11:7];
    assign w_funct3 = i_insn[14:12];
    assign o_rs1    = i_insn[19:15];
    assign o_rs2    = i_insn[24:20];
    assign w_funct7 = i_insn[31:25];

    assign w_imm_i = {{20{i_insn[31]}}, i_insn[31:20]};
    assign w_imm_s = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
    assign w_imm_b = {{19{i_insn[31]}}, i_insn[31], i_insn[7], i_insn[30:25], i_insn[11:8], 1'b0};
    assign w_imm_u = {i_insn[31:12], 12'b0};
    assign w_imm_j = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12], i_insn[20], i_insn[30:21], 1'b0};
    assign w_shamt = {{(WORD_DATA_BUS-REG_ADDR_BUS){1'b0}}, o_rs2};

`ifdef ID_FWD_EN
    logic w_ex_hit_0, w_ex_hit_1, w_mem_hit_0, w_mem_hit_1;

    // Loads in EX have no data yet, so they never forward; the hazard stalls them instead.
    assign w_ex_hit_0  = i_ex_en & i_ex_gpr_we & ~i_ex_is_load & (i_ex_dst_addr == o_rs1);
    assign w_ex_hit_1  = i_ex_en & i_ex_gpr_we & ~i_ex_is_load & (i_ex_dst_addr == o_rs2);
    assign w_mem_hit_0 = i_mem_en & i_mem_gpr_we & (i_mem_dst_addr == o_rs1);
    assign w_mem_hit_1 = i_mem_en & i_mem_gpr_we & (i_mem_dst_addr == o_rs2);

    assign w_rs1_data = (o_rs1 == '0) ? '0 : w_ex_hit_0 ? i_ex_fwd_data :
                        w_mem_hit_0 ? i_mem_fwd_data : i_rf_data_0;
    assign w_rs2_data = (o_rs2 == '0) ? '0 : w_ex_hit_1 ? i_ex_fwd_data :
                        w_mem_hit_1 ? i_mem_fwd_data : i_rf_data_1;

    assign o_ld_hazard = i_if_en & i_ex_en & i_ex_is_load & (i_ex_dst_addr != '0) &
                         ((w_use_rs1 & (i_ex_dst_addr == o_rs1)) |
                          (w_use_rs2 & (i_ex_dst_addr == o_rs2)));
`else
    logic w_unused_fwd;
    logic w_ex_raw, w_mem_raw;

    assign w_unused_fwd = i_ex_is_load ^ (^i_ex_fwd_data) ^ (^i_mem_fwd_data);

    assign w_rs1_data = (o_rs1 == '0) ? '0 : i_rf_data_0;
    assign w_rs2_data = (o_rs2 == '0) ? '0 : i_rf_data_1;

    assign w_ex_raw  = i_ex_en & i_ex_gpr_we & (i_ex_dst_addr != '0) &
                       ((w_use_rs1 & (i_ex_dst_addr == o_rs1)) |
                        (w_use_rs2 & (i_ex_dst_addr == o_rs2)));
    assign w_mem_raw = i_mem_en & i_mem_gpr_we & (i_mem_dst_addr != '0) &
                       ((w_use_rs1 & (i_mem_dst_addr == o_rs1)) |
                        (w_use_rs2 & (i_mem_dst_addr == o_rs2)));

    assign o_ld_hazard = i_if_en & (w_ex_raw | w_mem_raw);
`endif

    always_comb begin
        o_alu_op      = ALU_OP_NOP;
        o_alu_in_0    = w_rs1_data;
        o_alu_in_1    = w_rs2_data;
        o_mem_op      = MEM_OP_NOP;
        o_mem_wr_data = w_rs2_data;
        o_dst_addr    = '0;
        o_gpr_we      = 1'b0;
        o_exp_code    = EXP_NONE;
        w_use_rs1     = 1'b0;
        w_use_rs2     = 1'b0;
        w_is_jal      = 1'b0;
        w_is_jalr     = 1'b0;
        w_is_branch   = 1'b0;
        w_illegal     = 1'b0;
        case (w_opcode)
            OPC_LUI: begin
                o_alu_op = ALU_OP_ADD; o_alu_in_0 = '0; o_alu_in_1 = w_imm_u;
                o_dst_addr = w_rd; o_gpr_we = 1'b1;
            end
            OPC_AUIPC: begin
                o_alu_op = ALU_OP_ADD; o_alu_in_0 = i_pc; o_alu_in_1 = w_imm_u;
                o_dst_addr = w_rd; o_gpr_we = 1'b1;
            end
            OPC_JAL: begin
                o_alu_op = ALU_OP_ADD; o_alu_in_0 = i_pc; o_alu_in_1 = 32'd4;
                o_dst_addr = w_rd; o_gpr_we = 1'b1; w_is_jal = 1'b1;
            end
            OPC_JALR: begin
                w_use_rs1 = 1'b1;
                o_alu_op = ALU_OP_ADD; o_alu_in_0 = i_pc; o_alu_in_1 = 32'd4;
                o_dst_addr = w_rd; o_gpr_we = 1'b1; w_is_jalr = 1'b1;
                w_illegal = (w_funct3 != 3'd0);
            end
            OPC_BRANCH: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_is_branch = 1'b1;
                w_illegal = (w_funct3 == 3'd2) || (w_funct3 == 3'd3);
            end
            OPC_LOAD: begin
                w_use_rs1 = 1'b1;
                o_alu_op = ALU_OP_ADD; o_alu_in_1 = w_imm_i;
                o_dst_addr = w_rd; o_gpr_we = 1'b1;
                case (w_funct3)
                    F3_LB:   o_mem_op = MEM_OP_LB;
                    F3_LH:   o_mem_op = MEM_OP_LH;
                    F3_LW:   o_mem_op = MEM_OP_LW;
                    F3_LBU:  o_mem_op = MEM_OP_LBU;
                    F3_LHU:  o_mem_op = MEM_OP_LHU;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                o_alu_op = ALU_OP_ADD; o_alu_in_1 = w_imm_s;
                case (w_funct3)
                    F3_SB:   o_mem_op = MEM_OP_SB;
                    F3_SW:   o_mem_op = MEM_OP_SW;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                w_use_rs1 = 1'b1;
                o_alu_in_1 = w_imm_i; o_dst_addr = w_rd; o_gpr_we = 1'b1;
                case (w_funct3)
                    F3_ADD:  o_alu_op = ALU_OP_ADD;
                    F3_SLT:  o_alu_op = ALU_OP_SLT;
                    F3_SLTU: o_alu_op = ALU_OP_SLTU;
                    F3_XOR:  o_alu_op = ALU_OP_XOR;
                    F3_OR:   o_alu_op = ALU_OP_OR;
                    F3_AND:  o_alu_op = ALU_OP_AND;
                    F3_SLL: begin
                        o_alu_op = ALU_OP_SLL; o_alu_in_1 = w_shamt;
                        w_illegal = (w_funct7 != F7_BASE);
                    end
                    default: begin
                        o_alu_op = (w_funct7 == F7_ALT) ? ALU_OP_SRA : ALU_OP_SRL;
                        o_alu_in_1 = w_shamt;
                        w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
                    end
                endcase
            end
            OPC_OP: begin
                w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                o_dst_addr = w_rd; o_gpr_we = 1'b1;
                if (w_funct7 == F7_BASE) begin
                    case (w_funct3)
                        F3_ADD:  o_alu_op = ALU_OP_ADD;
                        F3_SLL:  o_alu_op = ALU_OP_SLL;
                        F3_SLT:  o_alu_op = ALU_OP_SLT;
                        F3_SLTU: o_alu_op = ALU_OP_SLTU;
                        F3_XOR:  o_alu_op = ALU_OP_XOR;
                        F3_SR:   o_alu_op = ALU_OP_SRL;
                        F3_OR:   o_alu_op = ALU_OP_OR;
                        default: o_alu_op = ALU_OP_AND;
                    endcase
                end else if (w_funct7 == F7_ALT && w_funct3 == F3_ADD) begin
                    o_alu_op = ALU_OP_SUB;
                end else if (w_funct7 == F7_ALT && w_funct3 == F3_SR) begin
                    o_alu_op = ALU_OP_SRA;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            o_alu_op    = ALU_OP_NOP;
            o_mem_op    = MEM_OP_NOP;
            o_dst_addr  = '0;
            o_gpr_we    = 1'b0;
            o_exp_code  = EXP_ILLEGAL;
            w_is_jal    = 1'b0;
            w_is_jalr   = 1'b0;
            w_is_branch = 1'b0;
        end
    end

    always_comb begin
        w_br_cond = 1'b0;
        case (w_funct3)
            F3_BEQ:  w_br_cond = (w_rs1_data == w_rs2_data);
            F3_BNE:  w_br_cond = (w_rs1_data != w_rs2_data);
            F3_BLT:  w_br_cond = ($signed(w_rs1_data) <  $signed(w_rs2_data));
            F3_BGE:  w_br_cond = ($signed(w_rs1_data) >= $signed(w_rs2_data));
            F3_BLTU: w_br_cond = (w_rs1_data <  w_rs2_data);
            F3_BGEU: w_br_cond = (w_rs1_data >= w_rs2_data);
            default: w_br_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_target   = '0;
        w_redirect = 1'b0;
        if (w_is_jal) begin
            w_target   = i_pc + w_imm_j;
            w_redirect = 1'b1;
        end else if (w_is_jalr) begin
            w_target   = (w_rs1_data + w_imm_i) & ~32'd1;
            w_redirect = 1'b1;
        end else if (w_is_branch) begin
            w_target   = i_pc + w_imm_b;
            w_redirect = w_br_cond;
        end
    end

    assign o_br_taken = i_if_en & ~o_ld_hazard & ~i_stall & ~i_flush & w_redirect;
    assign o_br_addr  = o_br_taken ? w_target : '0;

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage with the ID/EX pipeline register.
// Optional macro ID_FWD_EN (see id_stage_decoder). Revision: 1.0
`default_nettype none

module id_stage
    import id_stage_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     flush,
    input  logic [WORD_DATA_BUS-1:0] if_pc,
    input  logic [WORD_DATA_BUS-1:0] if_insn,
    input  logic                     if_en,
    output logic [REG_ADDR_BUS-1:0]  gpr_rd_addr_0,
    output logic [REG_ADDR_BUS-1:0]  gpr_rd_addr_1,
    input  logic [WORD_DATA_BUS-1:0] gpr_rd_data_0,
    input  logic [WORD_DATA_BUS-1:0] gpr_rd_data_1,
    input  logic                     ex_en,
    input  logic                     ex_gpr_we,
    input  logic [REG_ADDR_BUS-1:0]  ex_dst_addr,
    input  logic                     ex_is_load,
    input  logic [WORD_DATA_BUS-1:0] ex_fwd_data,
    input  logic                     mem_en,
    input  logic                     mem_gpr_we,
    input  logic [REG_ADDR_BUS-1:0]  mem_dst_addr,
    input  logic [WORD_DATA_BUS-1:0] mem_fwd_data,
    output logic                     br_taken,
    output logic [WORD_DATA_BUS-1:0] br_addr,
    output logic                     ld_hazard,
    output logic [WORD_DATA_BUS-1:0] id_pc,
    output logic                     id_en,
    output logic [3:0]               id_alu_op,
    output logic [WORD_DATA_BUS-1:0] id_alu_in_0,
    output logic [WORD_DATA_BUS-1:0] id_alu_in_1,
    output logic [2:0]               id_mem_op,
    output logic [WORD_DATA_BUS-1:0] id_mem_wr_data,
    output logic [REG_ADDR_BUS-1:0]  id_dst_addr,
    output logic                     id_gpr_we,
    output logic [1:0]               id_exp_code
);

    logic [3:0]               w_alu_op;
    logic [WORD_DATA_BUS-1:0] w_alu_in_0, w_alu_in_1, w_mem_wr_data;
    logic [2:0]               w_mem_op;
    logic [REG_ADDR_BUS-1:0]  w_dst_addr;
    logic                     w_gpr_we;
    logic [1:0]               w_exp_code;

    logic [WORD_DATA_BUS-1:0] r_pc, r_alu_in_0, r_alu_in_1, r_mem_wr_data;
    logic                     r_en, r_gpr_we;
    logic [3:0]               r_alu_op;
    logic [2:0]               r_mem_op;
    logic [REG_ADDR_BUS-1:0]  r_dst_addr;
    logic [1:0]               r_exp_code;

    id_stage_decoder u_decoder (
        .i_pc           (if_pc),
        .i_insn         (if_insn),
        .i_if_en        (if_en),
        .i_stall        (stall),
        .i_flush        (flush),
        .o_rs1          (gpr_rd_addr_0),
        .o_rs2          (gpr_rd_addr_1),
        .i_rf_data_0    (gpr_rd_data_0),
        .i_rf_data_1    (gpr_rd_data_1),
        .i_ex_en        (ex_en),
        .i_ex_gpr_we    (ex_gpr_we),
        .i_ex_dst_addr  (ex_dst_addr),
        .i_ex_is_load   (ex_is_load),
        .i_ex_fwd_data  (ex_fwd_data),
        .i_mem_en       (mem_en),
        .i_mem_gpr_we   (mem_gpr_we),
        .i_mem_dst_addr (mem_dst_addr),
        .i_mem_fwd_data (mem_fwd_data),
        .o_br_taken     (br_taken),
        .o_br_addr      (br_addr),
        .o_ld_hazard    (ld_hazard),
        .o_alu_op       (w_alu_op),
        .o_alu_in_0     (w_alu_in_0),
        .o_alu_in_1     (w_alu_in_1),
        .o_mem_op       (w_mem_op),
        .o_mem_wr_data  (w_mem_wr_data),
        .o_dst_addr     (w_dst_addr),
        .o_gpr_we       (w_gpr_we),
        .o_exp_code     (w_exp_code)
    );

    // Flush and hazard bubbles clear only the controls; data fields keep their last values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= '0;
            r_en          <= 1'b0;
            r_alu_op      <= ALU_OP_NOP;
            r_alu_in_0    <= '0;
            r_alu_in_1    <= '0;
            r_mem_op      <= MEM_OP_NOP;
            r_mem_wr_data <= '0;
            r_dst_addr    <= '0;
            r_gpr_we      <= 1'b0;
            r_exp_code    <= EXP_NONE;
        end else if (flush || (!stall && ld_hazard)) begin
            r_en       <= 1'b0;
            r_gpr_we   <= 1'b0;
            r_mem_op   <= MEM_OP_NOP;
            r_exp_code <= EXP_NONE;
        end else if (!stall) begin
            r_pc          <= if_pc;
            r_alu_op      <= w_alu_op;
            r_alu_in_0    <= w_alu_in_0;
            r_alu_in_1    <= w_alu_in_1;
            r_mem_wr_data <= w_mem_wr_data;
            r_dst_addr    <= w_dst_addr;
            r_en          <= if_en;
            r_gpr_we      <= if_en & w_gpr_we;
            r_mem_op      <= if_en ? w_mem_op : MEM_OP_NOP;
            r_exp_code    <= if_en ? w_exp_code : EXP_NONE;
        end
    end

    assign id_pc          = r_pc;
    assign id_en          = r_en;
    assign id_alu_op      = r_alu_op;
    assign id_alu_in_0    = r_alu_in_0;
    assign id_alu_in_1    = r_alu_in_1;
    assign id_mem_op      = r_mem_op;
    assign id_mem_wr_data = r_mem_wr_data;
    assign id_dst_addr    = r_dst_addr;
    assign id_gpr_we      = r_gpr_we;
    assign id_exp_code    = r_exp_code;

endmodule

`default_nettype wire
